// File: rtl/uart_rx_packetizer.sv
// Frames the uart_rx byte stream into SOF/LEN/payload/XOR-checksum packets and
// releases each payload on a valid/ready/last stream only after its checksum verifies.
`timescale 1ns/1ps
module uart_rx_packetizer #(
    parameter logic [7:0] SOF           = 8'h7E,
    parameter int         MAX_LEN       = 16,
    parameter int         TIMEOUT_TICKS = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       pkt_ok,
    output logic       crc_err,
    output logic       len_err,
    output logic       timeout,
    output logic       overrun,
    output logic       busy
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHECK, S_SEND} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [LW-1:0]   r_len;
    logic [LW-1:0]   r_wr_idx;
    logic [LW-1:0]   r_rd_idx;
    logic [7:0]      r_chk;
    logic [TW-1:0]   r_tmo_cnt;
    logic [7:0]      r_buf [MAX_LEN];

    logic            r_pkt_ok, r_crc_err, r_len_err, r_timeout, r_overrun;
    logic            w_pkt_ok_next, w_crc_err_next, w_len_err_next, w_timeout_next, w_overrun_next;

    logic [LW-1:0]   w_len_m1;
    logic            w_len_bad;
    logic            w_tmo_active;
    logic            w_tmo_fire;
    logic            w_chk_match;
    logic            w_xfer;
    logic            w_rd_last;
    logic            w_wr_last;

    assign w_len_m1     = r_len - LW'(1);
    assign w_len_bad    = (rx_data == 8'd0) || (int'(rx_data) > MAX_LEN);
    assign w_tmo_active = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHECK);
    // A byte arriving together with the terminal tick takes priority over the timeout.
    assign w_tmo_fire   = w_tmo_active && s_tick && !rx_done_tick &&
                          (r_tmo_cnt == TW'(TIMEOUT_TICKS - 1));
    assign w_chk_match  = (rx_data == r_chk);
    assign w_xfer       = (r_state == S_SEND) && out_ready;
    assign w_rd_last    = (r_rd_idx == w_len_m1);
    assign w_wr_last    = (r_wr_idx == w_len_m1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_tmo_fire) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (rx_done_tick && rx_data == SOF) w_state_next = S_LEN;
                S_LEN:     if (rx_done_tick) w_state_next = w_len_bad ? S_IDLE : S_PAYLOAD;
                S_PAYLOAD: if (rx_done_tick && w_wr_last) w_state_next = S_CHECK;
                S_CHECK:   if (rx_done_tick) w_state_next = w_chk_match ? S_SEND : S_IDLE;
                S_SEND:    if (w_xfer && w_rd_last) w_state_next = S_IDLE;
                default:   w_state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        out_valid      = (r_state == S_SEND);
        out_last       = (r_state == S_SEND) && w_rd_last;
        out_data       = (r_state == S_SEND) ? r_buf[r_rd_idx[AW-1:0]] : 8'h00;
        busy           = (r_state != S_IDLE);
        w_timeout_next = w_tmo_fire;
        w_len_err_next = (r_state == S_LEN)   && rx_done_tick && w_len_bad;
        w_pkt_ok_next  = (r_state == S_CHECK) && rx_done_tick && w_chk_match;
        w_crc_err_next = (r_state == S_CHECK) && rx_done_tick && !w_chk_match;
        w_overrun_next = (r_state == S_SEND)  && rx_done_tick;
    end

    // Payload store has no reset so it maps onto plain memory.
    always_ff @(posedge clk) begin
        if (r_state == S_PAYLOAD && rx_done_tick) begin
            r_buf[r_wr_idx[AW-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len     <= '0;
            r_wr_idx  <= '0;
            r_rd_idx  <= '0;
            r_chk     <= '0;
            r_tmo_cnt <= '0;
            r_pkt_ok  <= 1'b0;
            r_crc_err <= 1'b0;
            r_len_err <= 1'b0;
            r_timeout <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_pkt_ok  <= w_pkt_ok_next;
            r_crc_err <= w_crc_err_next;
            r_len_err <= w_len_err_next;
            r_timeout <= w_timeout_next;
            r_overrun <= w_overrun_next;

            if (!w_tmo_active || rx_done_tick || w_tmo_fire) begin
                r_tmo_cnt <= '0;
            end else if (s_tick) begin
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
            end

            if (rx_done_tick) begin
                if (r_state == S_LEN && !w_len_bad) begin
                    r_len    <= rx_data[LW-1:0];
                    r_chk    <= rx_data;
                    r_wr_idx <= '0;
                end else if (r_state == S_PAYLOAD) begin
                    r_chk    <= r_chk ^ rx_data;
                    r_wr_idx <= r_wr_idx + LW'(1);
                end else if (r_state == S_CHECK && w_chk_match) begin
                    r_rd_idx <= '0;
                end
            end

            if (w_xfer) begin
                r_rd_idx <= r_rd_idx + LW'(1);
            end
        end
    end

    assign pkt_ok  = r_pkt_ok;
    assign crc_err = r_crc_err;
    assign len_err = r_len_err;
    assign timeout = r_timeout;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_uart_rx_packetizer.sv
// Scoreboard bench for uart_rx_packetizer: expected payload bytes are queued when a
// good frame is sent and popped as the DUT hands them over.
`timescale 1ns/1ps
module tb_uart_rx_packetizer;

    localparam logic [7:0] SOF = 8'h7E;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       s_tick = 1'b0;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_valid, out_last, pkt_ok, crc_err, len_err, timeout, overrun, busy;

    always #5 clk = ~clk;

    uart_rx_packetizer dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .pkt_ok       (pkt_ok),
        .crc_err      (crc_err),
        .len_err      (len_err),
        .timeout      (timeout),
        .overrun      (overrun),
        .busy         (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [8:0] exp_q[$];
    int cnt_pkt_ok = 0, cnt_crc_err = 0, cnt_len_err = 0, cnt_timeout = 0, cnt_overrun = 0;
    int cnt_valid = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin : mon
        logic [8:0] e;
        if (reset) begin
            cnt_pkt_ok  += int'(pkt_ok);
            cnt_crc_err += int'(crc_err);
            cnt_len_err += int'(len_err);
            cnt_timeout += int'(timeout);
            cnt_overrun += int'(overrun);
            cnt_valid   += int'(out_valid);
            if (out_valid && out_ready) begin
                $display("xfer data=%02h last=%0b", out_data, out_last);
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_xfer", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("out_data", {24'd0, out_data}, {24'd0, e[7:0]});
                    check_eq("out_last", {31'd0, out_last}, {31'd0, e[8]});
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data      = b;
        rx_done_tick = 1'b1;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
        rx_data      = 8'($urandom);
    endtask

    // Payload byte i = seed + i*step; checksum covers LEN and payload.
    task automatic send_frame(input logic [7:0] len, input logic [7:0] seed,
                              input logic [7:0] step, input bit corrupt);
        logic [7:0] chk;
        logic [7:0] d;
        chk = len;
        send_byte(SOF);
        send_byte(len);
        for (int i = 0; i < int'(len); i++) begin
            d   = seed + 8'(i * int'(step));
            chk = chk ^ d;
            if (!corrupt) exp_q.push_back({(i == int'(len) - 1), d});
            send_byte(d);
        end
        $display("frame len=%0d chk=%02h corrupt=%0b", len, chk, corrupt);
        send_byte(corrupt ? (chk ^ 8'hFD) : chk);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && !busy) break;
        end
        check_eq({tag, "_drained"}, exp_q.size(), 32'd0);
        check_eq({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int v0, p0, e0;

        // Reset state
        #12;
        check_eq("reset_outs", {23'd0, busy, out_valid, out_last, pkt_ok, crc_err,
                 len_err, timeout, overrun, 1'b0} | {24'd0, out_data}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);

        // 1: good packet, latency of out_valid and pkt_ok
        out_ready = 1'b1;
        p0 = cnt_pkt_ok;
        send_frame(8'd3, 8'h11, 8'h11, 1'b0);
        check_eq("t1_valid_latency", {31'd0, out_valid}, 32'd1);
        check_eq("t1_pkt_ok_pulse", {31'd0, pkt_ok}, 32'd1);
        drain("t1");
        check_eq("t1_pkt_ok_count", cnt_pkt_ok - p0, 32'd1);

        // 2: bad checksum, then good packet
        v0 = cnt_valid; e0 = cnt_crc_err;
        send_frame(8'd2, 8'hAA, 8'hAB, 1'b1);
        check_eq("t2_crc_err_pulse", {31'd0, crc_err}, 32'd1);
        repeat (5) @(posedge clk);
        check_eq("t2_crc_err_count", cnt_crc_err - e0, 32'd1);
        check_eq("t2_no_valid", cnt_valid - v0, 32'd0);
        check_eq("t2_idle", {31'd0, busy}, 32'd0);
        send_frame(8'd1, 8'h5A, 8'h00, 1'b0);
        drain("t2_good");

        // 3: length limits
        e0 = cnt_len_err;
        send_byte(SOF);
        send_byte(8'h00);
        check_eq("t3_len0_err", {31'd0, len_err}, 32'd1);
        check_eq("t3_len0_idle", {31'd0, busy}, 32'd0);
        send_byte(SOF);
        send_byte(8'h11);
        check_eq("t3_len17_err", {31'd0, len_err}, 32'd1);
        check_eq("t3_len17_idle", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        check_eq("t3_len_err_count", cnt_len_err - e0, 32'd2);
        send_frame(8'd16, 8'h03, 8'h07, 1'b0);
        drain("t3_max");

        // 4: inter-byte timeout exactly on the 480th tick
        e0 = cnt_timeout;
        send_byte(SOF);
        send_byte(8'h02);
        send_byte(8'hAA);
        for (int i = 1; i <= 480; i++) begin
            s_tick = 1'b1;
            @(posedge clk); #1;
            s_tick = 1'b0;
            if (i == 479) begin
                check_eq("t4_no_early_timeout", {31'd0, timeout}, 32'd0);
                check_eq("t4_busy_before", {31'd0, busy}, 32'd1);
            end
        end
        check_eq("t4_timeout_pulse", {31'd0, timeout}, 32'd1);
        check_eq("t4_idle", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        check_eq("t4_timeout_count", cnt_timeout - e0, 32'd1);
        send_frame(8'd1, 8'h5A, 8'h00, 1'b0);
        drain("t4_good");

        // 5: backpressure and overrun
        out_ready = 1'b0;
        e0 = cnt_overrun;
        send_frame(8'd3, 8'h01, 8'h01, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_eq("t5_hold_valid", {31'd0, out_valid}, 32'd1);
            check_eq("t5_hold_data", {24'd0, out_data}, 32'h01);
        end
        send_byte(SOF);
        check_eq("t5_overrun_pulse", {31'd0, overrun}, 32'd1);
        check_eq("t5_data_after_ovr", {24'd0, out_data}, 32'h01);
        check_eq("t5_last_after_ovr", {31'd0, out_last}, 32'd0);
        out_ready = 1'b1;
        drain("t5");
        check_eq("t5_overrun_count", cnt_overrun - e0, 32'd1);

        // 6: async reset mid-payload
        e0 = cnt_crc_err + cnt_len_err + cnt_timeout + cnt_overrun;
        send_byte(SOF);
        send_byte(8'h04);
        send_byte(8'h11);
        send_byte(8'h22);
        reset = 1'b0;
        #2;
        check_eq("t6_reset_outs", {23'd0, busy, out_valid, out_last, pkt_ok, crc_err,
                 len_err, timeout, overrun, 1'b0} | {24'd0, out_data}, 32'd0);
        #5;
        reset = 1'b1;
        send_frame(8'd2, 8'hC3, 8'h05, 1'b0);
        drain("t6_good");
        check_eq("t6_no_err_pulse", cnt_crc_err + cnt_len_err + cnt_timeout + cnt_overrun - e0, 32'd0);

        check_eq("total_pkt_ok", cnt_pkt_ok, 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
